// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing constants, the source-operand request type and the hazard
// helper used by the register scoreboard.
package reg_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam int SB_CNT_W   = 2;

  typedef struct packed {
    logic                  used;
    logic [REG_ADDR_W-1:0] addr;
  } src_req_t;

  // A pending write blocks a read unless its sole outstanding producer is
  // forwarded from EX or written through REGS in this same cycle.
  function automatic logic sb_hazard(
    input logic src_nz,
    input logic cnt_nz,
    input logic cnt_one,
    input logic ex_hit,
    input logic wb_hit,
    input logic bypass
  );
    return src_nz & cnt_nz & ~(ex_hit & cnt_one) & ~(bypass & wb_hit & cnt_one);
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register count of in-flight writes: up on issue, down on retire,
// saturating at the top and never wrapping below zero.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r;
  logic             dec_eff_s;

  assign dec_eff_s = dec & (cnt_r != CNT_ZERO);
  assign underflow = dec & (cnt_r == CNT_ZERO) & ~inc;
  assign cnt       = cnt_r;

  // Count register; a same-cycle issue and retire cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (inc & ~dec_eff_s & (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else if (dec_eff_s & ~inc) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: tracks in-flight writes from ID issue to WB
// retire and stalls ID on hazards that EX forwarding or REGS write-through
// cannot hide.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG      = REG_NUM,
  parameter int CNT_W     = SB_CNT_W,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ID_vld,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_rs1_used,
  input  logic                  ID_rs2_used,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  input  logic                  ID_rd_vld,
  input  logic [REG_ADDR_W-1:0] EX_rd,
  input  logic                  EX_x_rd_vld,
  input  logic [REG_ADDR_W-1:0] WB_rd,
  input  logic                  WB_vld,
  input  logic                  PL_flush,
  output logic                  SB_stall,
  output logic                  SB_issue,
  output logic [NREG-1:0]       SB_pending,
  output logic                  SB_busy,
  output logic                  SB_err
);

  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1'b1);
  localparam logic [REG_ADDR_W-1:0] X0       = {REG_ADDR_W{1'b0}};

  logic [CNT_W-1:0] cnt_s [NREG];
  logic [NREG-1:0]  inc_s;
  logic [NREG-1:0]  dec_s;
  logic [NREG-1:0]  unf_s;
  logic [CNT_W-1:0] rs1_cnt_s;
  logic [CNT_W-1:0] rs2_cnt_s;
  logic [CNT_W-1:0] rd_cnt_s;
  src_req_t         rs1_s;
  src_req_t         rs2_s;
  logic             rs1_hz_s;
  logic             rs2_hz_s;
  logic             sat_s;
  logic             stall_s;
  logic             issue_s;
  logic             flush_guard_r;
  logic             err_r;

  assign rs1_s     = '{used: ID_rs1_used, addr: ID_rs1};
  assign rs2_s     = '{used: ID_rs2_used, addr: ID_rs2};
  assign rs1_cnt_s = cnt_s[rs1_s.addr];
  assign rs2_cnt_s = cnt_s[rs2_s.addr];
  assign rd_cnt_s  = cnt_s[ID_rd];

  assign rs1_hz_s = sb_hazard(rs1_s.addr != X0, rs1_cnt_s != CNT_ZERO, rs1_cnt_s == CNT_ONE,
                              EX_x_rd_vld & (EX_rd == rs1_s.addr),
                              WB_vld & (WB_rd == rs1_s.addr), WB_BYPASS);
  assign rs2_hz_s = sb_hazard(rs2_s.addr != X0, rs2_cnt_s != CNT_ZERO, rs2_cnt_s == CNT_ONE,
                              EX_x_rd_vld & (EX_rd == rs2_s.addr),
                              WB_vld & (WB_rd == rs2_s.addr), WB_BYPASS);

  // Saturated counter back-pressures a further WAW issue unless one retires now.
  assign sat_s = ID_rd_vld & (ID_rd != X0) & (rd_cnt_s == CNT_MAX) & ~(WB_vld & (WB_rd == ID_rd));

  // Stall decision, held low during reset.
  always_comb begin
    stall_s = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else if (ID_vld) begin
      stall_s = (rs1_s.used & rs1_hz_s) | (rs2_s.used & rs2_hz_s) | sat_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign issue_s  = ID_vld & ~stall_s & ~PL_flush & ~rst;
  assign SB_stall = stall_s;
  assign SB_issue = issue_s;

  assign cnt_s[0]      = CNT_ZERO;
  assign inc_s[0]      = 1'b0;
  assign dec_s[0]      = 1'b0;
  assign unf_s[0]      = 1'b0;
  assign SB_pending[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    assign inc_s[r] = issue_s & ID_rd_vld & (ID_rd == REG_ADDR_W'(r));
    assign dec_s[r] = WB_vld & (WB_rd == REG_ADDR_W'(r));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_s[r]),
      .dec       (dec_s[r]),
      .clr       (PL_flush),
      .cnt       (cnt_s[r]),
      .underflow (unf_s[r])
    );

    assign SB_pending[r] = (cnt_s[r] != CNT_ZERO);
  end

  assign SB_busy = |SB_pending;

  // Sticky underflow error; retires draining just past a flush are expected and masked.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_guard_r <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      flush_guard_r <= PL_flush;
      if ((|unf_s) & ~flush_guard_r) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign SB_err = err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios followed by
// random traffic, all compared against a count-per-register reference model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_vld, ID_rs1_used, ID_rs2_used, ID_rd_vld;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd, EX_rd, WB_rd;
  logic        EX_x_rd_vld, WB_vld, PL_flush;
  logic        SB_stall, SB_issue, SB_busy, SB_err;
  logic [31:0] SB_pending;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding writes per register, sticky error, flush shadow.
  int mcnt [32];
  bit merr;
  bit mguard;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .ID_vld(ID_vld), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_rd(ID_rd), .ID_rd_vld(ID_rd_vld),
    .EX_rd(EX_rd), .EX_x_rd_vld(EX_x_rd_vld),
    .WB_rd(WB_rd), .WB_vld(WB_vld), .PL_flush(PL_flush),
    .SB_stall(SB_stall), .SB_issue(SB_issue), .SB_pending(SB_pending),
    .SB_busy(SB_busy), .SB_err(SB_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_hz(input int r);
    if (r == 0 || mcnt[r] == 0) return 1'b0;
    if (mcnt[r] == 1 && EX_x_rd_vld && int'(EX_rd) == r) return 1'b0;
    if (mcnt[r] == 1 && WB_vld && int'(WB_rd) == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    if (rst || !ID_vld) return 1'b0;
    if (ID_rs1_used && m_hz(int'(ID_rs1))) return 1'b1;
    if (ID_rs2_used && m_hz(int'(ID_rs2))) return 1'b1;
    if (ID_rd_vld && ID_rd != 5'd0 && mcnt[ID_rd] == 3 && !(WB_vld && WB_rd == ID_rd)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_update(input bit issued);
    bit unf = 1'b0;
    bit inc, ret;
    if (rst) begin
      foreach (mcnt[r]) mcnt[r] = 0;
      merr   = 1'b0;
      mguard = 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        inc = issued && ID_rd_vld && int'(ID_rd) == r;
        ret = WB_vld && int'(WB_rd) == r;
        if (inc && ret && mcnt[r] > 0) begin
          // issue replaces the retiring write
        end else if (inc) begin
          mcnt[r] = (mcnt[r] < 3) ? mcnt[r] + 1 : 3;
        end else if (ret) begin
          if (mcnt[r] > 0) mcnt[r]--;
          else unf = 1'b1;
        end
      end
      if (unf && !mguard) merr = 1'b1;
      if (PL_flush) foreach (mcnt[r]) mcnt[r] = 0;
      mguard = PL_flush;
    end
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p = 32'd0;
    for (int r = 1; r < 32; r++) p[r] = (mcnt[r] != 0);
    return p;
  endfunction

  task automatic idle();
    rst = 1'b0; ID_vld = 1'b0; ID_rs1_used = 1'b0; ID_rs2_used = 1'b0; ID_rd_vld = 1'b0;
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_rd = 5'd0; EX_rd = 5'd0; EX_x_rd_vld = 1'b0;
    WB_rd = 5'd0; WB_vld = 1'b0; PL_flush = 1'b0;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    idle(); ID_vld = 1'b1; ID_rd_vld = 1'b1; ID_rd = rd;
  endtask

  task automatic retire(input logic [4:0] rd);
    idle(); WB_vld = 1'b1; WB_rd = rd;
  endtask

  // One clock: check combinational outputs mid-cycle, then registered state after the edge.
  task automatic cycle(input string tag, input int ws = -1, input int wbusy = -1, input int werr = -1);
    bit es, ei;
    #2;
    es = m_stall();
    ei = ID_vld && !es && !PL_flush && !rst;
    chk({tag, ".stall"}, {31'd0, SB_stall}, {31'd0, es});
    chk({tag, ".issue"}, {31'd0, SB_issue}, {31'd0, ei});
    if (ws >= 0) chk({tag, ".stall_dir"}, {31'd0, SB_stall}, 32'(ws));
    @(posedge clk);
    m_update(ei);
    #1;
    chk({tag, ".pending"}, SB_pending, m_pending());
    chk({tag, ".busy"}, {31'd0, SB_busy}, {31'd0, |m_pending()});
    chk({tag, ".err"}, {31'd0, SB_err}, {31'd0, merr});
    if (wbusy >= 0) chk({tag, ".busy_dir"}, {31'd0, SB_busy}, 32'(wbusy));
    if (werr >= 0) chk({tag, ".err_dir"}, {31'd0, SB_err}, 32'(werr));
  endtask

  initial begin
    int q [$];
    foreach (mcnt[r]) mcnt[r] = 0;
    merr = 1'b0; mguard = 1'b0;
    idle(); rst = 1'b1;
    cycle("reset", 0, 0, 0);
    chk("reset.pending_zero", SB_pending, 32'd0);

    idle(); ID_vld = 1'b1; ID_rs1 = 5'd3; ID_rs1_used = 1'b1;
    cycle("clean_read", 0, 0);

    issue_rd(5'd5);                       cycle("issue5", 0, 1);
    chk("issue5.pend_bit", {31'd0, SB_pending[5]}, 32'd1);
    idle(); ID_vld = 1'b1; ID_rs2 = 5'd5; ID_rs2_used = 1'b1; EX_rd = 5'd5; EX_x_rd_vld = 1'b1;
    cycle("fwd5", 0);
    EX_x_rd_vld = 1'b0;                   cycle("raw5_a", 1);
    cycle("raw5_b", 1);
    WB_vld = 1'b1; WB_rd = 5'd5;          cycle("wbp5", 0, 0);

    for (int i = 0; i < 3; i++) begin
      issue_rd(5'd7);                     cycle("issue7", 0);
    end
    issue_rd(5'd7);                       cycle("sat7", 1);
    WB_vld = 1'b1; WB_rd = 5'd7;          cycle("sat7_wb", 0);
    issue_rd(5'd7);                       cycle("sat7_again", 1);
    for (int i = 0; i < 3; i++) begin
      retire(5'd7);                       cycle("drain7", 0);
    end

    issue_rd(5'd9);                       cycle("issue9", 0, 1);
    issue_rd(5'd9); WB_vld = 1'b1; WB_rd = 5'd9; cycle("swap9", 0, 1);
    chk("swap9.pend_bit", {31'd0, SB_pending[9]}, 32'd1);
    retire(5'd9);                         cycle("drain9", 0, 0);

    issue_rd(5'd4);                       cycle("issue4");
    issue_rd(5'd6);                       cycle("issue6", -1, 1);
    idle(); PL_flush = 1'b1;              cycle("flush", -1, 0, 0);
    retire(5'd4);                         cycle("wb_after_flush", -1, 0, 0);
    idle();                               cycle("gap", -1, 0, 0);
    retire(5'd4);                         cycle("late_wb", -1, 0, 1);
    idle();                               cycle("err_sticky", -1, 0, 1);

    idle(); ID_vld = 1'b1; ID_rd_vld = 1'b1; ID_rd = 5'd0; ID_rs1 = 5'd0; ID_rs1_used = 1'b1;
    cycle("x0", 0, 0, 1);
    retire(5'd0);                         cycle("wb_x0", -1, 0, 1);

    issue_rd(5'd10);                      cycle("issue10", 0, 1);
    idle(); ID_vld = 1'b1; ID_rs1 = 5'd10; ID_rs1_used = 1'b1;
    cycle("stall10", 1);
    rst = 1'b1;                           cycle("rst_mid", 0, 0, 0);
    chk("rst_mid.pending_zero", SB_pending, 32'd0);

    for (int n = 0; n < 600; n++) begin
      idle();
      rst         = ($urandom_range(0, 79) == 0);
      PL_flush    = ($urandom_range(0, 39) == 0);
      ID_vld      = ($urandom_range(0, 3) != 0);
      ID_rs1      = 5'($urandom_range(0, 7));
      ID_rs2      = 5'($urandom_range(0, 7));
      ID_rs1_used = $urandom_range(0, 1) == 1;
      ID_rs2_used = $urandom_range(0, 1) == 1;
      ID_rd       = 5'($urandom_range(0, 7));
      ID_rd_vld   = ($urandom_range(0, 3) != 0);
      EX_rd       = 5'($urandom_range(0, 7));
      EX_x_rd_vld = $urandom_range(0, 1) == 1;
      q.delete();
      for (int r = 1; r < 32; r++) if (mcnt[r] != 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        WB_vld = 1'b1;
        WB_rd  = 5'(q[$urandom_range(0, q.size() - 1)]);
      end else if ($urandom_range(0, 15) == 0) begin
        WB_vld = 1'b1;
        WB_rd  = 5'($urandom_range(0, 7));
      end
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
